piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer; next generation of the 4-bit PISO register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, MSB- or LSB-first as selected per word. Status outputs mark the first bit, the last bit, and bit validity. Words can be chained back-to-back with no idle cycle, so it can feed serial links and bit-banged peripherals directly.

---
 rtl/piso_serializer_if.sv | 42 ++++
 rtl/piso_serializer.sv | 119 +++++++++++
 tb/tb_piso_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Load/serial bundle for piso_serializer.
// The source drives the master side; the serializer takes the slave side.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             msb_first;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             first;
    logic             last;
    logic             busy;

    modport master (
        output parallel_in,
        output load_valid,
        output msb_first,
        output shift_en,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  first,
        input  last,
        input  busy
    );

    modport slave (
        input  parallel_in,
        input  load_valid,
        input  msb_first,
        input  shift_en,
        output load_ready,
        output serial_out,
        output serial_valid,
        output first,
        output last,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer with valid/ready load and back-to-back frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    piso_serializer_if.slave bus
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int N = WIDTH + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    localparam int N = WIDTH;
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_DATA_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic             order;
    logic [CW-1:0]    cnt;
    logic             valid;
    logic             at_last;
    logic             consume;
    logic             accept;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par;
`endif

    assign valid   = (state != IDLE);
    assign at_last = valid && (cnt == CNT_LAST);
    assign consume = valid && bus.shift_en;

    // Ready may rise on the final bit so the next word loads with no gap.
    assign bus.load_ready = !reset &&
                            ((state == IDLE) || (at_last && bus.shift_en));
    assign accept = bus.load_valid && bus.load_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = SHIFT;
            end
            SHIFT: begin
                if (consume && (cnt == CNT_DATA_LAST)) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: begin
                if (consume) state_nx = accept ? SHIFT : IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // A load on the final-bit edge takes priority over the shift.
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg  <= '0;
            order <= 1'b0;
            cnt   <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            sreg  <= bus.parallel_in;
            order <= bus.msb_first;
            cnt   <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par   <= ^bus.parallel_in;
`endif
        end else if (consume) begin
            sreg <= order ? (sreg << 1) : (sreg >> 1);
            cnt  <= at_last ? '0 : cnt + CW'(1);
        end
    end

    always_comb begin
        bus.serial_out = IDLE_LEVEL;
        unique case (state)
            SHIFT: begin
                bus.serial_out = order ? sreg[WIDTH-1] : sreg[0];
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: begin
                bus.serial_out = par;
            end
`endif
            default: bus.serial_out = IDLE_LEVEL;
        endcase
        bus.serial_valid = valid;
        bus.first        = valid && (cnt == '0);
        bus.last         = at_last;
        bus.busy         = valid;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: WIDTH=4 (idle 0) and WIDTH=8 (idle 1).
// Honours PISO_SERIALIZER_PARITY_EN for frame length and parity bits.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N4 = 4 + P;
    localparam int N8 = 8 + P;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    piso_serializer_if #(.WIDTH(4)) b4 ();
    piso_serializer_if #(.WIDTH(8)) b8 ();

    piso_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0)) u4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4.slave)
    );

    piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u8 (
        .clock (clock),
        .reset (reset),
        .bus   (b8.slave)
    );

    // expected bit i of a frame; index >= w is the parity bit
    function automatic logic eb(logic [63:0] word, int w, logic msb, int i);
        if (i >= w) return ^word;
        return msb ? word[w-1-i] : word[i];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load4(logic [3:0] word, logic msb);
        b4.parallel_in = word;
        b4.msb_first   = msb;
        b4.load_valid  = 1'b1;
        b4.shift_en    = 1'b1;
        tick();
        b4.load_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        logic [5:0] want;
        reset = 1'b1;
        tick();
        tick();
        got  = {b4.serial_out, b4.serial_valid, b4.first,
                b4.last, b4.busy, b4.load_ready};
        want = 6'b000000;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset4 got=%b want=%b", got, want);
        end
        got  = {b8.serial_out, b8.serial_valid, b8.first,
                b8.last, b8.busy, b8.load_ready};
        want = 6'b100000;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset8 got=%b want=%b", got, want);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({b4.load_ready, b8.load_ready} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_reset got=%b want=11",
                     {b4.load_ready, b8.load_ready});
        end
    endtask

    task automatic test_order(logic [3:0] word, logic msb, string nm);
        logic [5:0] got;
        logic [5:0] want;
        total++;
        if (b4.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_ready got=%b want=1", nm, b4.load_ready);
        end
        load4(word, msb);
        // order is frozen at accept
        b4.msb_first = ~msb;
        for (int i = 0; i < N4; i++) begin
            got  = {b4.serial_out, b4.serial_valid, b4.first,
                    b4.last, b4.busy, b4.load_ready};
            want = {eb(64'(word), 4, msb, i), 1'b1, i == 0,
                    i == N4 - 1, 1'b1, i == N4 - 1};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s bit%0d got=%b want=%b", nm, i, got, want);
            end
            tick();
        end
        got  = {b4.serial_out, b4.serial_valid, b4.first,
                b4.last, b4.busy, b4.load_ready};
        want = 6'b000001;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s idle got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w0 = 4'b1010;
        logic [3:0] w1 = 4'b0011;
        logic [5:0] got;
        logic [5:0] want;
        logic       bit_e;
        int         j;
        b4.parallel_in = w0;
        b4.msb_first   = 1'b1;
        b4.load_valid  = 1'b1;
        b4.shift_en    = 1'b1;
        tick();
        b4.parallel_in = w1;
        for (int i = 0; i < 2 * N4; i++) begin
            j     = i % N4;
            bit_e = (i < N4) ? eb(64'(w0), 4, 1'b1, j)
                             : eb(64'(w1), 4, 1'b1, j);
            got  = {b4.serial_out, b4.serial_valid, b4.first,
                    b4.last, b4.busy, b4.load_ready};
            want = {bit_e, 1'b1, j == 0, j == N4 - 1, 1'b1, j == N4 - 1};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b cyc%0d got=%b want=%b", i + 1, got, want);
            end
            tick();
            if (i == N4 - 1) b4.load_valid = 1'b0;
        end
        got  = {b4.serial_out, b4.serial_valid, b4.busy, b4.load_ready};
        total++;
        if (got[3:0] !== 4'b0001) begin
            bad++;
            $display("FAIL b2b idle got=%b want=0001", got[3:0]);
        end
    endtask

    task automatic test_hold();
        logic [7:0] w = 8'hC5;
        logic [5:0] got;
        logic [5:0] want;
        logic       se;
        int         k = 0;
        b8.parallel_in = w;
        b8.msb_first   = 1'b1;
        b8.load_valid  = 1'b1;
        b8.shift_en    = 1'b1;
        tick();
        b8.load_valid  = 1'b0;
        for (int c = 0; c < N8 + 3; c++) begin
            se = !(c >= 2 && c <= 4);
            b8.shift_en = se;
            #1;
            got  = {b8.serial_out, b8.serial_valid, b8.first,
                    b8.last, b8.busy, b8.load_ready};
            want = {eb(64'(w), 8, 1'b1, k), 1'b1, k == 0,
                    k == N8 - 1, 1'b1, (k == N8 - 1) && se};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hold cyc%0d got=%b want=%b", c + 1, got, want);
            end
            tick();
            if (se) k++;
        end
        got  = {b8.serial_out, b8.serial_valid, b8.first,
                b8.last, b8.busy, b8.load_ready};
        want = 6'b100001;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL hold idle got=%b want=%b", got, want);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        logic [5:0] want;
        b8.parallel_in = 8'hFF;
        b8.msb_first   = 1'b1;
        b8.load_valid  = 1'b1;
        b8.shift_en    = 1'b1;
        tick();
        b8.load_valid  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({b8.serial_out, b8.serial_valid} !== 2'b11) begin
                bad++;
                $display("FAIL rst_mid bit%0d got=%b want=11", i,
                         {b8.serial_out, b8.serial_valid});
            end
            tick();
        end
        // reset beats a simultaneous load attempt
        reset = 1'b1;
        b8.parallel_in = 8'h00;
        b8.load_valid  = 1'b1;
        #1;
        total++;
        if (b8.load_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid ready_in_reset got=%b want=0",
                     b8.load_ready);
        end
        tick();
        got  = {b8.serial_out, b8.serial_valid, b8.first,
                b8.last, b8.busy, b8.load_ready};
        want = 6'b100000;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL rst_mid abort got=%b want=%b", got, want);
        end
        b8.load_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (b8.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid ready_after got=%b want=1", b8.load_ready);
        end
        tick();
        total++;
        if ({b8.serial_out, b8.serial_valid, b8.busy} !== 3'b100) begin
            bad++;
            $display("FAIL rst_mid still_idle got=%b want=100",
                     {b8.serial_out, b8.serial_valid, b8.busy});
        end
    endtask

    initial begin
        b4.parallel_in = '0;
        b4.load_valid  = 1'b0;
        b4.msb_first   = 1'b1;
        b4.shift_en    = 1'b0;
        b8.parallel_in = '0;
        b8.load_valid  = 1'b0;
        b8.msb_first   = 1'b1;
        b8.shift_en    = 1'b0;
        test_reset();
        test_order(4'b1010, 1'b1, "msb");
        test_order(4'b1010, 1'b0, "lsb");
        test_back_to_back();
        test_hold();
        test_reset_mid();
`ifdef PISO_SERIALIZER_PARITY_EN
        test_order(4'b1011, 1'b1, "par_msb");
        test_order(4'b1011, 1'b0, "par_lsb");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
